// File: rtl/seq_det_sched.sv
// seq_det_sched: round-robin (or fixed-priority) scheduler that time-shares
// one bit-serial sequence detector among NREQ requesters. Each granted word
// is serialized LSB-first after a one-cycle detector clear. After HIT_LAT
// wait cycles the detector's match flag is latched into hit[g] and done[g]
// pulses for one cycle.
//
// Build option: define SEQ_DET_SCHED_RR_EN for round-robin arbitration with a
// rotating start pointer. Left undefined, the lowest requesting index wins and
// no pointer is built.
//
// Handshake: req[i] is a level request that is only looked at while the FSM is
// idle. gnt[i] acknowledges it and stays high for the whole job. done[i] is the
// single-cycle completion strobe, and the requester drops req[i] on it. The
// serial side is push-only: ser_bit is meaningful exactly in cycles where
// ser_vld is high, and the detector cannot stall it.
module seq_det_sched #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int HIT_LAT = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  output logic [NREQ-1:0]         done,
  output logic [NREQ-1:0]         hit,
  output logic                    busy,
  output logic                    ser_clr,
  output logic                    ser_vld,
  output logic                    ser_bit,
  input  logic                    det_hit,
  output logic [2:0]              dbg_state
);

  localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNTW = $clog2(WIDTH + 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [CNTW-1:0] BIT_LAST = CNTW'(WIDTH - 1);
  localparam logic [2:0]      LAT_LAST = (HIT_LAT > 0) ? 3'(HIT_LAT - 1) : 3'd0;

  logic [2:0]       state_q, state_d;
  logic [NREQ-1:0]  gnt_q,   gnt_d;
  logic [IDXW-1:0]  idx_q,   idx_d;
  logic [WIDTH-1:0] sh_q,    sh_d;
  logic [CNTW-1:0]  cnt_q,   cnt_d;
  logic [2:0]       lat_q,   lat_d;
  logic [NREQ-1:0]  hit_q,   hit_d;

  logic             win_found;
  logic [IDXW-1:0]  win_idx;
  logic [IDXW-1:0]  cand;
  logic [WIDTH-1:0] win_word;

`ifdef SEQ_DET_SCHED_RR_EN
  logic [IDXW-1:0]  ptr_q, ptr_d;
`endif

  // Arbitration: first requester found scanning upward from the start index.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef SEQ_DET_SCHED_RR_EN
      cand = IDXW'((int'(ptr_q) + k) % NREQ);
`else
      cand = IDXW'(k);
`endif
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Word select for the arbitration winner.
  always_comb begin
    win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDXW'(i)) win_word = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Job sequencing: load, clear detector, shift, wait for the flag, report.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    hit_d   = hit_q;
`ifdef SEQ_DET_SCHED_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          state_d        = ST_CLR;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          idx_d          = win_idx;
          sh_d           = win_word;
          cnt_d          = '0;
          lat_d          = '0;
        end
      end
      ST_CLR: begin
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        sh_d  = sh_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (HIT_LAT == 0) begin
            // No settling time: the flag is already final after the last bit.
            state_d      = ST_DONE;
            hit_d[idx_q] = det_hit;
          end else begin
            state_d = ST_WAIT;
            lat_d   = '0;
          end
        end
      end
      ST_WAIT: begin
        lat_d = lat_q + 1'b1;
        if (lat_q == LAT_LAST) begin
          state_d      = ST_DONE;
          hit_d[idx_q] = det_hit;
          lat_d        = '0;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
`ifdef SEQ_DET_SCHED_RR_EN
        ptr_d   = IDXW'((int'(idx_q) + 1) % NREQ);
`endif
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State registers; reset abandons any job in flight without a done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      lat_q   <= '0;
      hit_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      hit_q   <= hit_d;
    end
  end

`ifdef SEQ_DET_SCHED_RR_EN
  // Rotating start pointer: the requester after the last one served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`endif

  assign gnt       = gnt_q;
  assign done      = (state_q == ST_DONE) ? gnt_q : '0;
  assign hit       = hit_q;
  assign busy      = (state_q != ST_IDLE);
  assign ser_clr   = (state_q == ST_CLR);
  assign ser_vld   = (state_q == ST_SHIFT);
  assign ser_bit   = (state_q == ST_SHIFT) & sh_q[0];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: directed jobs with hand-computed done timing,
// grant and hit vectors queued as expectations; a done monitor pops and
// compares. A small detector model (0101 in arrival order, sticky until
// ser_clr) drives det_hit.
module tb_seq_det_sched;

  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int HIT_LAT = 2;
  localparam int RW      = 16 + 3 * NREQ;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt, done, hit;
  logic                  busy, ser_clr, ser_vld, ser_bit, det_hit;
  logic [2:0]            dbg_state;

  seq_det_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .HIT_LAT(HIT_LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .req_data  (req_data),
    .gnt       (gnt),
    .done      (done),
    .hit       (hit),
    .busy      (busy),
    .ser_clr   (ser_clr),
    .ser_vld   (ser_vld),
    .ser_bit   (ser_bit),
    .det_hit   (det_hit),
    .dbg_state (dbg_state)
  );

  // ---------------- detector model ----------------
  logic [3:0] hist;
  logic       sticky;
  logic       det_q;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist <= '0; sticky <= 1'b0; det_q <= 1'b0;
    end else if (ser_clr) begin
      hist <= '0; sticky <= 1'b0; det_q <= 1'b0;
    end else begin
      if (ser_vld) begin
        hist <= {hist[2:0], ser_bit};
        if ({hist[2:0], ser_bit} == 4'b0101) sticky <= 1'b1;
      end
      det_q <= sticky;
    end
  end
  assign det_hit = det_q;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [RW-1:0] exp_q[$];
  logic [RW-1:0] mon_got, mon_want;

  task automatic push_exp(input int c, input logic [NREQ-1:0] d, input logic [NREQ-1:0] h);
    exp_q.push_back({16'(c), d, d, h});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the next expected job.
  always @(negedge clk) begin
    if (rst_n && done != '0) begin
      mon_got = {16'(cyc), done, gnt, hit};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL done_unexpected: got cyc=%0d done=%b gnt=%b hit=%b want none",
                 cyc, done, gnt, hit);
      end else begin
        mon_want = exp_q.pop_front();
        if (mon_got !== mon_want) begin
          n_err++;
          $display("FAIL done_job: got cyc=%0d done=%b gnt=%b hit=%b want cyc=%0d done=%b gnt=%b hit=%b",
                   mon_got[RW-1 -: 16], mon_got[3*NREQ-1 -: NREQ], mon_got[2*NREQ-1 -: NREQ],
                   mon_got[NREQ-1:0], mon_want[RW-1 -: 16], mon_want[3*NREQ-1 -: NREQ],
                   mon_want[2*NREQ-1 -: NREQ], mon_want[NREQ-1:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic at_cycle(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_stream(input int t, input logic [7:0] word, input bit mutate);
    for (int i = 0; i < 8; i++) begin
      at_cycle(t + 2 + i);
      if (mutate && i == 1) begin
        req            = '0;
        req_data[7:0]  = 8'h00;
      end
      check("ser_vld", 32'(ser_vld), 32'd1);
      check("ser_bit", 32'(ser_bit), 32'(word[i]));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  int t1, t2, t3, t4, t5, t6, t7, t8;

  initial begin
    rst_n    = 1'b0;
    req      = '0;
    req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt",     32'(gnt),     32'd0);
    check("rst_done",    32'(done),    32'd0);
    check("rst_hit",     32'(hit),     32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    check("rst_ser_clr", 32'(ser_clr), 32'd0);
    check("rst_ser_vld", 32'(ser_vld), 32'd0);
    rst_n = 1'b1;

    // Single job, hit
    t1 = cyc + 2;
    at_cycle(t1);
    req = 4'b0001; req_data[7:0] = 8'hA5;
    push_exp(t1 + 12, 4'b0001, 4'b0001);
    at_cycle(t1 + 1);
    check("clr_ser_clr", 32'(ser_clr), 32'd1);
    check("clr_ser_vld", 32'(ser_vld), 32'd0);
    check("clr_gnt",     32'(gnt),     32'b0001);
    check("clr_busy",    32'(busy),    32'd1);
    check_stream(t1, 8'hA5, 1'b0);
    at_cycle(t1 + 10);
    check("wait_ser_vld", 32'(ser_vld), 32'd0);
    check("wait_gnt",     32'(gnt),     32'b0001);
    at_cycle(t1 + 12);
    req = '0;
    at_cycle(t1 + 13);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_gnt",  32'(gnt),  32'd0);
    check("idle_done", 32'(done), 32'd0);

    // Miss on requester 2, hit[0] retained
    t2 = t1 + 13;
    req = 4'b0100; req_data[23:16] = 8'hFF;
    push_exp(t2 + 12, 4'b0100, 4'b0001);
    at_cycle(t2 + 12);
    req = '0;

    // Request dropped and data changed during SHIFT
    t3 = t2 + 13;
    at_cycle(t3);
    req = 4'b0001; req_data[7:0] = 8'hA5;
    push_exp(t3 + 12, 4'b0001, 4'b0001);
    check_stream(t3, 8'hA5, 1'b1);

    // Build hit = 0010 ahead of the reset test
    t4 = t3 + 13;
    at_cycle(t4);
    req = 4'b0010; req_data[15:8] = 8'hA5;
    push_exp(t4 + 12, 4'b0010, 4'b0011);
    at_cycle(t4 + 12);
    req = '0;
    t5 = t4 + 13;
    at_cycle(t5);
    req = 4'b0001; req_data[7:0] = 8'hFF;
    push_exp(t5 + 12, 4'b0001, 4'b0010);
    at_cycle(t5 + 12);
    req = '0;

    // Reset in the middle of a requester-1 job
    t6 = t5 + 13;
    at_cycle(t6);
    req = 4'b0010;
    at_cycle(t6 + 5);
    check("pre_rst_hit",  32'(hit),  32'b0010);
    check("pre_rst_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    req   = '0;
    #1;
    check("mid_rst_gnt",     32'(gnt),     32'd0);
    check("mid_rst_busy",    32'(busy),    32'd0);
    check("mid_rst_hit",     32'(hit),     32'd0);
    check("mid_rst_ser_vld", 32'(ser_vld), 32'd0);
    at_cycle(t6 + 7);
    rst_n = 1'b1;
    at_cycle(t6 + 20);
    check("post_rst_busy",    32'(busy),    32'd0);
    check("post_rst_ser_clr", 32'(ser_clr), 32'd0);
    t7 = t6 + 20;
    req = 4'b1000; req_data[31:24] = 8'h00;
    push_exp(t7 + 12, 4'b1000, 4'b0000);
    at_cycle(t7 + 1);
    check("post_rst_gnt", 32'(gnt), 32'b1000);
    at_cycle(t7 + 12);
    req = '0;

    // Arbitration under held requests
    t8 = t7 + 13;
    at_cycle(t8);
`ifdef SEQ_DET_SCHED_RR_EN
    req      = 4'b1111;
    req_data = {8'h00, 8'h0A, 8'hFF, 8'hA5};
    push_exp(t8 + 12, 4'b0001, 4'b0001);
    push_exp(t8 + 25, 4'b0010, 4'b0001);
    push_exp(t8 + 38, 4'b0100, 4'b0101);
    push_exp(t8 + 51, 4'b1000, 4'b0101);
    push_exp(t8 + 64, 4'b0001, 4'b0101);
    at_cycle(t8 + 64);
    req = '0;
    at_cycle(t8 + 70);
`else
    req      = 4'b1010;
    req_data = {8'h0A, 8'h00, 8'hA5, 8'h00};
    push_exp(t8 + 12, 4'b0010, 4'b0010);
    push_exp(t8 + 25, 4'b0010, 4'b0010);
    push_exp(t8 + 38, 4'b0010, 4'b0010);
    push_exp(t8 + 51, 4'b1000, 4'b1010);
    at_cycle(t8 + 38);
    req = 4'b1000;
    at_cycle(t8 + 51);
    req = '0;
    at_cycle(t8 + 57);
`endif

    // ---------------- final report ----------------
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    check("end_busy",    32'(busy),         32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Round-robin scheduler that shares one bit-serial sequence-detector engine among `NREQ` requesters. Each requester presents an 8-bit word. The block grants one requester at a time, clears the detector and serializes the word LSB-first into it. After a fixed detector latency it samples the detector's match flag and returns a per-requester result with a done pulse. It sits between the switch/button front ends and the single detector FSM.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `WIDTH`, default 8: bits per job.
- `HIT_LAT`, default 2: cycles from the last serial bit until `det_hit` is valid, 0..7.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req` in NREQ: level request, one bit per requester.
- `req_data` in NREQ*WIDTH: the word for requester i is `[i*WIDTH +: WIDTH]`.
- `gnt` out NREQ: one-hot grant, held for the whole job.
- `done` out NREQ: one-cycle pulse on the served requester at job end.
- `hit` out NREQ: per-requester match result, held until that requester's next job completes.
- `busy` out 1: high whenever the state is not IDLE.
- `ser_clr` out 1: one-cycle detector clear at job start.
- `ser_vld` out 1: serial bit valid.
- `ser_bit` out 1: serial data, LSB first.
- `det_hit` in 1: detector match flag.

## Operation
- States: IDLE, CLR, SHIFT, WAIT, DONE.
- **IDLE:** when `req != 0`, pick a winner by round-robin. The search starts at `ptr` and moves upward with wrap. Register `gnt`, load the winner's word into the shift register and go to CLR.
- **CLR:** one cycle. `ser_clr=1`, `ser_vld=0`. Go to SHIFT.
- **SHIFT:** `WIDTH` cycles. `ser_vld=1`, `ser_bit=sh[0]`, shift right every cycle. The bit counter is `$clog2(WIDTH+1)` bits wide. After the last bit, go to WAIT, or go directly to DONE when `HIT_LAT=0`.
- **WAIT:** `HIT_LAT` cycles with `ser_vld=0`. Go to DONE.
- **Result capture:** `det_hit` is sampled on the edge that enters DONE and written into `hit[g]` only. All other `hit` bits are unchanged.
- **DONE:** one cycle. `done[g]=1`. `ptr` becomes `(g+1) mod NREQ`. `gnt` clears on exit. Go to IDLE.
- `req` is only examined in IDLE.
  - Dropping `req` mid-job does not abort the job.
  - `req_data` changes after load are ignored.
  - A requester still holding `req` after its `done` is re-arbitrated normally. Requesters must drop `req` on `done`.
- Simultaneous requests: exactly one grant is issued. The others wait. Under continuous load, no requester waits more than NREQ-1 jobs.
- **Reset**, asynchronous at any time including mid-job:
  - state = IDLE, `ptr` = 0, shift register and counter = 0.
  - All outputs 0, including `hit`.
  - No `done` is issued for an aborted job.
  - The detector sees no `ser_clr` until the next job.

## Timing
- Request sampled in IDLE at cycle t.
- CLR and `gnt` are valid at t+1.
- Serial bits are driven at t+2 .. t+1+WIDTH.
- WAIT runs at t+2+WIDTH .. t+1+WIDTH+HIT_LAT.
- DONE is at t+2+WIDTH+HIT_LAT, which is t+12 with defaults.
- `hit[g]` is valid in the same cycle as `done[g]`.
- IDLE follows for one cycle, so back-to-back jobs start every WIDTH+HIT_LAT+3 cycles (13 with defaults).
- `busy` is high from t+1 through DONE inclusive.
- `gnt` is one-hot or zero at all times. It never changes between CLR and DONE.

## Configuration
- Macro: `SEQ_DET_SCHED_RR_EN`.
- Defined: round-robin arbitration with the rotating `ptr` described above.
- Undefined: fixed priority, lowest index wins. `ptr` and its update logic are not built. All other behaviour and timing are identical.

## Test plan
Bench model for the detector: `det_hit` rises `HIT_LAT` cycles after the serial stream, cleared by `ser_clr`, contains 0101 read in arrival order; it is held until the next `ser_clr`.
- **Single job, hit:** `req=4'b0001`, word `8'hA5` at cycle 0 → `ser_clr` at cycle 1; `ser_bit` = 1,0,1,0,0,1,0,1 over cycles 2–9; `done[0]` at cycle 12 with `hit[0]=1`; `busy` low at cycle 13.
- **Miss:** `req[2]`, word `8'hFF` → `done[2]` 12 cycles after the request; `hit[2]=0`; `hit[0]` keeps its prior value.
- **Round-robin fairness** (macro defined): `req=4'b1111` held throughout → grant order 0,1,2,3,0; consecutive `done` pulses 13 cycles apart.
- **Fixed priority** (macro undefined): `req=4'b1010` held throughout → every grant goes to requester 1; requester 3 is served only after `req[1]` drops.
- **Reset mid-job:** `rst_n` low during SHIFT of a requester-1 job with prior `hit=4'b0010` → immediately `gnt=0`, `busy=0`, `hit=0`, `ser_vld=0`; no `done` afterward; after release, `req[3]` is granted first (`ptr=0`, requesters 0–2 idle).
- **Request changes mid-job:** `req[0]` dropped and `req_data[7:0]` changed to `8'h00` during SHIFT of word `8'hA5` → serialized bits remain those of `8'hA5`; `done[0]` still pulses at cycle 12 with `hit[0]=1`.
